// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side signal bundle for the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            reqIn;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
  logic [NUM_REQ-1:0]            reqAckOut;
  logic [NUM_REQ-1:0]            grantOut;
  logic                          fifoIsFullIn;
  logic                          fifoWrEnOut;
  logic [DATA_WIDTH-1:0]         fifoWrDataOut;
  logic                          busyOut;

  // Arbiter view
  modport slave (
    input  reqIn, reqDataIn, fifoIsFullIn,
    output reqAckOut, grantOut, fifoWrEnOut, fifoWrDataOut, busyOut
  );

  // Environment view (requesters plus FIFO)
  modport master (
    output reqIn, reqDataIn, fifoIsFullIn,
    input  reqAckOut, grantOut, fifoWrEnOut, fifoWrDataOut, busyOut
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one shared FIFO write port
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input logic              clkIn,
  input logic              rstNIn,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} stateT;

  stateT              state;
  logic [NUM_REQ-1:0] grantReg;
  logic [IW-1:0]      ownerIdx;
  logic [IW-1:0]      lastGrant;
  logic [CW-1:0]      burstCnt;

  logic               winFound;
  logic [IW-1:0]      winIdx;
  logic [IW:0]        cand;
  logic               ownerReq;
  logic               xfer;
  logic               lastWord;

  // Round-robin search starting just after the previous winner; the loop
  // runs from lowest to highest priority so the nearest requester wins last.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, lastGrant} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (bus.reqIn[cand[IW-1:0]]) begin
        winFound = 1'b1;
        winIdx   = cand[IW-1:0];
      end
    end
  end

  // Only the owner's request matters; grantReg is zero outside a burst.
  assign ownerReq = |(bus.reqIn & grantReg);
  assign xfer     = (state == BURST) && ownerReq && !bus.fifoIsFullIn;
  assign lastWord = (burstCnt == CW'(BURST_LEN - 1));

  assign bus.fifoWrEnOut   = xfer;
  assign bus.reqAckOut     = xfer ? grantReg : '0;
  assign bus.grantOut      = grantReg;
  assign bus.busyOut       = (state == BURST);
  assign bus.fifoWrDataOut = (state == BURST) ?
                             bus.reqDataIn[ownerIdx*DATA_WIDTH +: DATA_WIDTH] : '0;

  // Arbitrate in IDLE, then own the FIFO until the burst fills or the owner drops.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state     <= IDLE;
      grantReg  <= '0;
      ownerIdx  <= '0;
      lastGrant <= IW'(NUM_REQ - 1);
      burstCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winFound) begin
            state     <= BURST;
            grantReg  <= NUM_REQ'(1) << winIdx;
            ownerIdx  <= winIdx;
            lastGrant <= winIdx;
            burstCnt  <= '0;
          end
        end
        BURST: begin
          if (xfer) begin
            burstCnt <= burstCnt + CW'(1);
          end
          if (!ownerReq || (xfer && lastWord)) begin
            state    <= IDLE;
            grantReg <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          grantReg <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clkIn (clk),
    .rstNIn(rstN),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic             full = 1'b0;
  logic [5:0]       prodCnt [NR];
  logic [NR-1:0]    lastAck = '0;
  logic [NR*DW-1:0] reqData;
  bit               fifoMode = 1'b0;

  int checks = 0;
  int failures = 0;

  int        logOwner[$];
  logic [DW-1:0] logData[$];
  logic [DW-1:0] fifoQ[$];
  int        fullWrites = 0;

  // Each requester offers {id, running count}; count advances after an ack.
  always_comb begin
    reqData = '0;
    for (int i = 0; i < NR; i++) begin
      reqData[i*DW +: DW] = {2'(i), prodCnt[i]};
    end
  end

  assign bus.reqIn        = req;
  assign bus.reqDataIn    = reqData;
  assign bus.fifoIsFullIn = full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: who owns the FIFO and how many words it has written.
  int mOwner = -1;
  int mCnt = 0;
  int mLast = NR - 1;
  int cIdx;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mOwner = -1;
      mCnt   = 0;
      mLast  = NR - 1;
    end else if (mOwner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        cIdx = (mLast + k) % NR;
        if (req[cIdx]) begin
          mOwner = cIdx;
          mLast  = cIdx;
          mCnt   = 0;
          break;
        end
      end
    end else if (!req[mOwner]) begin
      mOwner = -1;
    end else if (!full) begin
      mCnt++;
      if (mCnt == BL) mOwner = -1;
    end
  end

  // Per-cycle comparison against the model, plus logging of observed writes.
  logic [NR-1:0] eGrant;
  logic          eXfer;
  logic [DW-1:0] eData;
  int            gIdx;

  always @(negedge clk) begin
    eGrant = (mOwner >= 0) ? (NR'(1) << mOwner) : '0;
    eXfer  = (mOwner >= 0) && req[mOwner] && !full;
    eData  = (mOwner >= 0) ? reqData[mOwner*DW +: DW] : '0;
    chk("grant",  bus.grantOut, eGrant);
    chk("wrEn",   bus.fifoWrEnOut, eXfer);
    chk("ack",    bus.reqAckOut, eXfer ? eGrant : '0);
    chk("wrData", bus.fifoWrDataOut, eData);
    chk("busy",   bus.busyOut, mOwner >= 0);
    chk("onehot", $onehot0(bus.grantOut), 1);
    lastAck = bus.reqAckOut;
    if (bus.fifoWrEnOut === 1'b1) begin
      gIdx = -1;
      for (int i = 0; i < NR; i++) if (bus.grantOut[i]) gIdx = i;
      logOwner.push_back(gIdx);
      logData.push_back(bus.fifoWrDataOut);
      if (full) fullWrites++;
      if (fifoMode) fifoQ.push_back(bus.fifoWrDataOut);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (lastAck[i]) prodCnt[i] = prodCnt[i] + 6'd1;
      lastAck = '0;
      if (fifoMode) full = (fifoQ.size() >= 8);
    end
  endtask

  task automatic rel(input logic [NR-1:0] r);
    rstN = 1'b0;
    req  = r;
    full = 1'b0;
    for (int i = 0; i < NR; i++) prodCnt[i] = '0;
    lastAck = '0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    logOwner.delete();
    logData.delete();
    fifoQ.delete();
    fullWrites = 0;
  endtask

  logic [DW-1:0] expD;

  initial begin
    for (int i = 0; i < NR; i++) prodCnt[i] = '0;
    @(posedge clk);
    #1;
    chk("rst_grant", bus.grantOut, 0);
    chk("rst_busy",  bus.busyOut, 0);
    chk("rst_wrEn",  bus.fifoWrEnOut, 0);

    // Single requester: 4 writes, 1 idle, 4 writes, 1 idle, 2 writes
    rel(4'b0001);
    cyc(12);
    @(negedge clk); #1;
    chk("s034_count", logData.size(), 10);
    for (int k = 0; k < 10 && k < logData.size(); k++) begin
      expD = {2'd0, 6'(k)};
      chk($sformatf("s034_data%0d", k), logData[k], expD);
    end

    // All requesting: grants rotate 0,1,2,3,0 with 4 writes each
    rel(4'b1111);
    cyc(24);
    @(negedge clk); #1;
    chk("s035_count", logData.size(), 20);
    for (int k = 0; k < 20 && k < logData.size(); k++) begin
      chk($sformatf("s035_owner%0d", k), logOwner[k], (k / 4) % 4);
      expD = {2'((k / 4) % 4), 6'((k / 16) * 4 + k % 4)};
      chk($sformatf("s035_data%0d", k), logData[k], expD);
    end

    // FIFO full for 3 cycles after 2 writes
    rel(4'b0001);
    cyc(3);
    full = 1'b1;
    cyc(3);
    full = 1'b0;
    cyc(2);
    @(negedge clk); #1;
    chk("s036_count", logData.size(), 4);
    chk("s036_fullwr", fullWrites, 0);
    chk("s036_idle", bus.busyOut, 0);
    for (int k = 0; k < 4 && k < logData.size(); k++) begin
      expD = {2'd0, 6'(k)};
      chk($sformatf("s036_data%0d", k), logData[k], expD);
    end

    // Owner 2 drops after one write; requester 3 takes over
    rel(4'b1100);
    cyc(2);
    req = 4'b1000;
    cyc(3);
    @(negedge clk); #1;
    chk("s037_count", logOwner.size(), 3);
    if (logOwner.size() == 3) begin
      chk("s037_o0", logOwner[0], 2);
      chk("s037_o1", logOwner[1], 3);
      chk("s037_o2", logOwner[2], 3);
    end

    // Asynchronous reset mid-burst
    rel(4'b1111);
    cyc(2);
    #2;
    rstN = 1'b0;
    #1;
    chk("s038_grant",  bus.grantOut, 0);
    chk("s038_wrEn",   bus.fifoWrEnOut, 0);
    chk("s038_ack",    bus.reqAckOut, 0);
    chk("s038_busy",   bus.busyOut, 0);
    chk("s038_wrData", bus.fifoWrDataOut, 0);
    rel(4'b1010);
    cyc(1);
    @(negedge clk); #1;
    chk("s038_first", bus.grantOut, 4'b0010);

    // Depth-8 FIFO with no reads
    fifoMode = 1'b1;
    rel(4'b1111);
    cyc(30);
    @(negedge clk); #1;
    chk("s039_count", fifoQ.size(), 8);
    chk("s039_fullwr", fullWrites, 0);
    for (int k = 0; k < 8 && k < fifoQ.size(); k++) begin
      expD = {2'(k / 4), 6'(k % 4)};
      chk($sformatf("s039_data%0d", k), fifoQ[k], expD);
    end
    fifoMode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
